dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_ram.sv | 36 +++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the default address/data/burst-length widths, which the CPU core
// reuses, and the arbiter FSM state encoding.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 26;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic {
    IDLE      = 1'b0,
    DBG_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port data memory: synchronous write, registered read.
// Ports:
//   clk_i   - clock, all state on rising edge
//   we_i    - write enable for the current cycle's access
//   re_i    - read enable, loads rdata_o at the closing edge
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - registered read data, valid the cycle after re_i
// Contents are zero at power-up and are never cleared by reset.
module dmem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 26
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W] = '{default: '0};
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter between a CPU (single-beat) port and a debug (burst) port sharing
// one single-port data memory.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata           - CPU single-beat request
//   cpu_gnt, cpu_rvalid, cpu_rdata  - CPU grant and read return
//   dbg_req/we/addr/len/wdata       - debug burst request (len = beats - 1)
//   dbg_gnt, dbg_rvalid, dbg_rdata  - debug grant and read return
//   dbg_done                        - pulses on the final burst beat
// Grants are combinational; a beat moves whenever req and gnt are both high.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [LEN_W-1:0]  dbg_len,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done
);

  state_t            state_q, state_d;
  logic              rr_dbg_q, rr_dbg_d;   // 1: debug wins the next tie
  logic [ADDR_W-1:0] addr_q, addr_d;       // next burst address
  logic              we_q, we_d;           // latched burst direction
  logic [LEN_W-1:0]  rem_q, rem_d;         // beats left after the first
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  logic              cpu_gnt_raw, dbg_gnt_raw, done_raw;
  logic              acc_we, acc_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always_comb begin
    state_d      = state_q;
    rr_dbg_d     = rr_dbg_q;
    addr_d       = addr_q;
    we_d         = we_q;
    rem_d        = rem_q;
    cpu_gnt_raw  = 1'b0;
    dbg_gnt_raw  = 1'b0;
    done_raw     = 1'b0;
    acc_we       = 1'b0;
    acc_re       = 1'b0;
    mem_addr     = addr_q;
    mem_wdata    = dbg_wdata;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && !(dbg_req && rr_dbg_q)) begin
          cpu_gnt_raw  = 1'b1;
          mem_addr     = cpu_addr;
          mem_wdata    = cpu_wdata;
          acc_we       = cpu_we;
          acc_re       = !cpu_we;
          cpu_rvalid_d = !cpu_we;
          rr_dbg_d     = 1'b1;
        end else if (dbg_req) begin
          dbg_gnt_raw  = 1'b1;
          mem_addr     = dbg_addr;
          acc_we       = dbg_we;
          acc_re       = !dbg_we;
          dbg_rvalid_d = !dbg_we;
          we_d         = dbg_we;
          addr_d       = dbg_addr + ADDR_W'(1);
          rem_d        = dbg_len;
          rr_dbg_d     = 1'b0;
          if (dbg_len == '0) begin
            done_raw = 1'b1;
          end else begin
            state_d = DBG_BURST;
          end
        end
      end
      DBG_BURST: begin
        // The burst owns the memory; a dropped dbg_req only stalls it.
        dbg_gnt_raw = 1'b1;
        if (dbg_req) begin
          acc_we       = we_q;
          acc_re       = !we_q;
          dbg_rvalid_d = !we_q;
          addr_d       = addr_q + ADDR_W'(1);
          rem_d        = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_raw = 1'b1;
            state_d  = IDLE;
            rr_dbg_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset silences grants and memory strobes at once, not at the next edge.
  assign cpu_gnt  = cpu_gnt_raw & ~rst;
  assign dbg_gnt  = dbg_gnt_raw & ~rst;
  assign dbg_done = done_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_dbg_q     <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      rem_q        <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_dbg_q     <= rr_dbg_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      rem_q        <= rem_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      // Capture the returned word so rdata holds between reads.
      if (cpu_rvalid_q) cpu_rdata_q <= mem_rdata;
      if (dbg_rvalid_q) dbg_rdata_q <= mem_rdata;
    end
  end

  dmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (acc_we & ~rst),
    .re_i    (acc_re & ~rst),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [25:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [25:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [7:0]  dbg_addr;
  logic [3:0]  dbg_len;
  logic [25:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid, dbg_done;
  logic [25:0] dbg_rdata;

  int checks = 0;
  int errors = 0;
  int dbg_rv_cnt = 0;
  logic [25:0] cpu_q[$];
  logic [25:0] dbg_q[$];

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_len    (dbg_len),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_done   (dbg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic r, input logic w, input logic [7:0] a, input logic [25:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dbg_set(input logic r, input logic w, input logic [7:0] a,
                         input logic [3:0] l, input logic [25:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_len = l; dbg_wdata = d;
  endtask

  // Monitor: every read return is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
      else chk("cpu_rdata", {6'd0, cpu_rdata}, {6'd0, cpu_q.pop_front()});
    end
    if (dbg_rvalid) begin
      dbg_rv_cnt++;
      if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 32'd1, 32'd0);
      else chk("dbg_rdata", {6'd0, dbg_rdata}, {6'd0, dbg_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rv0;
    rst = 1'b1;
    cpu_set(1, 0, 8'h00, 26'h0);
    dbg_set(0, 0, 8'h00, 4'h0, 26'h0);
    // Reset state, with a CPU request pending
    cyc(); cyc(); #3;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_rvalids", {cpu_rvalid, dbg_rvalid}, 0);
    chk("rst_done", dbg_done, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    cyc(); rst = 1'b0; cpu_req = 0;

    // Both requesting continuously, single beats: CPU first, then alternate
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) begin
        cpu_set(1, 1, 8'h30, 26'h00A);
        dbg_set(1, 1, 8'h31, 4'h0, 26'h00B);
      end
      #3;
      chk("rr_cpu_gnt", cpu_gnt, (i % 2 == 0));
      chk("rr_dbg_gnt", dbg_gnt, (i % 2 == 1));
      chk("rr_dbg_done", dbg_done, (i % 2 == 1));
    end
    cyc(); cpu_set(1, 0, 8'h30, 0); dbg_req = 0; #3;
    chk("rb30_gnt", cpu_gnt, 1); cpu_q.push_back(26'h00A);
    cyc(); cpu_set(1, 0, 8'h31, 0); #3;
    chk("rb31_gnt", cpu_gnt, 1); cpu_q.push_back(26'h00B);

    // CPU write 0x10 then read back
    cyc(); cpu_set(1, 1, 8'h10, 26'h3FFFFFF); #3;
    chk("w10_gnt", cpu_gnt, 1);
    cyc(); cpu_set(1, 0, 8'h10, 0); #3;
    chk("r10_gnt", cpu_gnt, 1);
    cpu_q.push_back(26'h3FFFFFF);
    cyc(); cpu_req = 0; #3;
    chk("r10_rvalid", cpu_rvalid, 1);
    chk("r10_dbg_idle", {dbg_gnt, dbg_rvalid, dbg_done}, 0);
    cyc(); #3;
    chk("r10_rvalid_one_cycle", cpu_rvalid, 0);
    chk("r10_rdata_hold", cpu_rdata, 26'h3FFFFFF);

    // Write then read next cycle, same address
    cyc(); cpu_set(1, 1, 8'h20, 26'h155); #3;
    chk("w20_gnt", cpu_gnt, 1);
    cyc(); cpu_set(1, 0, 8'h20, 0); #3;
    chk("w20_no_rvalid", cpu_rvalid, 0);
    cpu_q.push_back(26'h155);
    cyc(); cpu_req = 0;

    // Debug write burst wrapping 0xFE..0x01, CPU held off throughout
    cyc(); cpu_set(1, 0, 8'h00, 0); dbg_set(1, 1, 8'hFE, 4'd3, 26'd1); #3;
    chk("wb1_dbg_gnt", dbg_gnt, 1);
    chk("wb1_cpu_gnt", cpu_gnt, 0);
    chk("wb1_done", dbg_done, 0);
    for (int b = 2; b <= 4; b++) begin
      // Address, length and direction are ignored once the burst is running
      cyc(); dbg_set(1, 0, 8'h55, 4'd0, 26'(b)); #3;
      chk("wb_dbg_gnt", dbg_gnt, 1);
      chk("wb_cpu_gnt", cpu_gnt, 0);
      chk("wb_done", dbg_done, (b == 4));
    end
    cyc(); dbg_req = 0; #3;
    chk("wb_cpu_after", cpu_gnt, 1); cpu_q.push_back(26'd3);
    cyc(); cpu_addr = 8'hFE; #3; chk("rbFE_gnt", cpu_gnt, 1); cpu_q.push_back(26'd1);
    cyc(); cpu_addr = 8'hFF; #3; chk("rbFF_gnt", cpu_gnt, 1); cpu_q.push_back(26'd2);
    cyc(); cpu_addr = 8'h01; #3; chk("rb01_gnt", cpu_gnt, 1); cpu_q.push_back(26'd4);
    cyc(); cpu_req = 0;
    cyc();

    // Debug read burst len 2 with a two-cycle stall after beat 1
    rv0 = dbg_rv_cnt;
    cyc(); dbg_set(1, 0, 8'hFE, 4'd2, 0); #3;
    chk("rs1_dbg_gnt", dbg_gnt, 1); dbg_q.push_back(26'd1);
    cyc(); dbg_req = 0; cpu_set(1, 0, 8'h31, 0); #3;
    chk("stall1_cpu_gnt", cpu_gnt, 0);
    chk("stall1_done", dbg_done, 0);
    cyc(); #3;
    chk("stall2_cpu_gnt", cpu_gnt, 0);
    chk("stall2_no_beat", dbg_rvalid, 0);
    cyc(); dbg_req = 1; #3;
    chk("rs2_cpu_gnt", cpu_gnt, 0);
    chk("rs2_done", dbg_done, 0); dbg_q.push_back(26'd2);
    cyc(); #3;
    chk("rs3_cpu_gnt", cpu_gnt, 0);
    chk("rs3_done", dbg_done, 1); dbg_q.push_back(26'd3);
    cyc(); dbg_req = 0; #3;
    chk("rs_cpu_after", cpu_gnt, 1); cpu_q.push_back(26'h00B);
    cyc(); cpu_req = 0;
    cyc(); cyc();
    chk("rs_rvalid_pulses", dbg_rv_cnt - rv0, 3);

    // Asynchronous reset during beat 2 of a len-5 read burst
    cyc(); dbg_set(1, 0, 8'hFE, 4'd5, 0); #3;
    chk("ab1_dbg_gnt", dbg_gnt, 1); dbg_q.push_back(26'd1);
    cyc(); #3;
    chk("ab2_dbg_gnt", dbg_gnt, 1);
    #3; rst = 1'b1; dbg_req = 0; #1;
    chk("ab_rst_gnt", {cpu_gnt, dbg_gnt}, 0);
    chk("ab_rst_done", dbg_done, 0);
    chk("ab_rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
    chk("ab_rst_rdata", {6'd0, dbg_rdata}, 0);
    #1; rst = 1'b0;
    cyc(); #3;
    chk("ab_no_rvalid", dbg_rvalid, 0);
    cyc(); dbg_set(1, 1, 8'h50, 4'd0, 26'h77); #3;
    chk("ab_idle_gnt", dbg_gnt, 1);
    chk("ab_idle_done", dbg_done, 1);
    cyc(); dbg_req = 0; cpu_set(1, 0, 8'h10, 0); #3;
    chk("ab_r10_gnt", cpu_gnt, 1); cpu_q.push_back(26'h3FFFFFF);
    cyc(); cpu_addr = 8'hFE; #3; cpu_q.push_back(26'd1);
    cyc(); cpu_addr = 8'h50; #3; cpu_q.push_back(26'h77);
    cyc(); cpu_req = 0;
    cyc(); cyc();

    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dbg_q_drained", dbg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
